wbagu: RTL and testbench
========================

WBAGU -- requirements
Module: wbagu

Interface
REQ-001 Parameter BWADDR, default 21: address bitwidth.
REQ-002 Parameter BWLENGTH, default 8: loop length and outer count bitwidth.
REQ-003 Parameter BWDATA, default 64: write data bitwidth.
REQ-004 Parameter NJUMPS, default 5: number of jumps; fixed at 5 (four inner loops plus the outer jump).
REQ-005 clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-006 clr  in  1  reset; synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; launches a write-back job when in IDLE.
REQ-008 baseaddr  in  BWADDR  first write address; sampled on accepted start.
REQ-009 count  in  BWLENGTH  outer-loop iterations; sampled on accepted start.
REQ-010 l[4:1]  in  BWLENGTH each  inner loop lengths; sampled on accepted start.
REQ-011 j[4:0]  in  BWADDR each  two's-complement address jumps; sampled on accepted start.
REQ-012 in_valid / in_data / in_ready  in / in BWDATA / out  result stream handshake.
REQ-013 mem_we / mem_addr / mem_wdata  out 1 / BWADDR / BWDATA  memory write request.
REQ-014 mem_gnt  in  1  memory accepts the request in the same cycle as mem_we=1.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 done  out  1  one-cycle pulse at job completion.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE.
REQ-018 Transitions: IDLE->RUN on start with count!=0; IDLE->DONE on start with count==0; RUN->DRAIN when the last word is accepted; DRAIN->DONE when the pending write is granted; DONE->IDLE unconditionally after one cycle.
REQ-019 On start, latch config, load cur_addr=baseaddr, counters i[X]=l[X], and outer counter oc=count.
REQ-020 start is ignored when the state is not IDLE.
REQ-021 Word accept: in_valid & in_ready; in_ready = (state==RUN) & (!mem_we | mem_gnt).
REQ-022 Accept latency: on the cycle after acceptance, mem_we=1, mem_addr=cur_addr as of acceptance, and mem_wdata=in_data.
REQ-023 mem_we, mem_addr and mem_wdata hold stable while mem_we=1 and mem_gnt=0.
REQ-024 mem_we clears on grant unless a new word is accepted in the same cycle (back-to-back accepts give full throughput).
REQ-025 Address step per accepted word, with zX = (i[X]==0):
  - z1..z4 all set: add j0, reload all i, decrement oc.
  - else z2..z4 set: add j1, reload i4..i2, decrement i1.
  - else z3,z4 set: add j2, reload i4,i3, decrement i2.
  - else z4 set: add j3, reload i4, decrement i3.
  - otherwise: add j4, decrement i4.
REQ-026 A job writes count*(l1+1)*(l2+1)*(l3+1)*(l4+1) words.
REQ-027 The last word is the one accepted when the j0 case occurs with oc==1.
REQ-028 Address arithmetic is modulo 2^BWADDR; sums wrap silently.
REQ-029 Data is never dropped or reordered; in_ready is 0 in IDLE, DRAIN and DONE.

Reset
REQ-030 On clr: state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, in_ready=0; all counters and cur_addr cleared.
REQ-031 clr mid-job abandons the job, drops any pending write and takes priority over start and mem_gnt.

Verification
REQ-032 l=0,0,0,0; j0=1; base=0x100; count=3; mem_gnt=1 -> writes to 0x100, 0x101, 0x102, then one done pulse, busy low.
REQ-033 l4=2, l1..l3=0; j4=4; j0=16; base=0; count=2 -> addresses 0, 4, 8, 24, 28, 32; done after the 6th grant.
REQ-034 Hold mem_gnt=0 for 3 cycles with a pending write -> mem_addr/mem_wdata stable, in_ready=0; resumes with no loss or duplication.
REQ-035 base=0x1FFFFF, j0=1, l=0, count=2 -> writes to 0x1FFFFF then 0x000000.
REQ-036 Assert clr after 2 of 6 words -> next cycle all outputs at reset values; a new start restarts from baseaddr with a full word count.
REQ-037 start with count=0 -> done pulse on the next cycle, mem_we never asserted; start pulsed during RUN has no effect.

Source files
------------

// File: rtl/wbagu.sv
// Write-back address generation unit: streams result words to memory, walking
// a five-level nested address pattern (four inner loops plus an outer repeat).
module wbagu #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int BWDATA   = 64,
  parameter int NJUMPS   = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [BWADDR-1:0]   baseaddr,
  input  logic [BWLENGTH-1:0] count,
  input  logic [BWLENGTH-1:0] l1,
  input  logic [BWLENGTH-1:0] l2,
  input  logic [BWLENGTH-1:0] l3,
  input  logic [BWLENGTH-1:0] l4,
  input  logic [BWADDR-1:0]   j0,
  input  logic [BWADDR-1:0]   j1,
  input  logic [BWADDR-1:0]   j2,
  input  logic [BWADDR-1:0]   j3,
  input  logic [BWADDR-1:0]   j4,
  input  logic                in_valid,
  input  logic [BWDATA-1:0]   in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [BWADDR-1:0]   mem_addr,
  output logic [BWDATA-1:0]   mem_wdata,
  input  logic                mem_gnt,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [BWADDR-1:0]                cur_addr_q, cur_addr_d;
  logic [BWLENGTH-1:0]              oc_q, oc_d;
  logic [NJUMPS-1:0][BWADDR-1:0]    jmp_q, jmp_d;
  logic                             mem_we_q, mem_we_d;
  logic [BWADDR-1:0]                mem_addr_q, mem_addr_d;
  logic [BWDATA-1:0]                mem_wdata_q, mem_wdata_d;

  logic [4:1][BWLENGTH-1:0]         l_in;
  logic [NJUMPS-1:0][BWADDR-1:0]    j_in;
  logic [4:1]                       z;
  logic [2:0]                       sel;
  logic                             start_ok;
  logic                             accept;
  logic                             last_word;

  assign l_in = {l4, l3, l2, l1};
  assign j_in = {j4, j3, j2, j1, j0};

  assign in_ready  = (state_q == S_RUN) & (~mem_we_q | mem_gnt);
  assign accept    = in_valid & in_ready;
  assign start_ok  = start & (state_q == S_IDLE);
  assign last_word = accept & (sel == 3'd0) & (oc_q == BWLENGTH'(1));

  // sel names the innermost loop that is NOT exhausted; 0 means all four wrapped.
  always_comb begin
    sel = 3'd4;
    if (z[4] & z[3] & z[2] & z[1]) sel = 3'd0;
    else if (z[4] & z[3] & z[2])   sel = 3'd1;
    else if (z[4] & z[3])          sel = 3'd2;
    else if (z[4])                 sel = 3'd3;
  end

  // Loop counter X reloads when any outer level advances and counts down when it is the active level.
  for (genvar gi = 1; gi <= 4; gi++) begin : g_cnt
    logic [BWLENGTH-1:0] len_q, len_d;
    logic [BWLENGTH-1:0] cnt_q, cnt_d;

    always_comb begin
      len_d = len_q;
      cnt_d = cnt_q;
      if (start_ok) begin
        len_d = l_in[gi];
        cnt_d = l_in[gi];
      end else if (accept) begin
        if (sel < 3'(gi))       cnt_d = len_q;
        else if (sel == 3'(gi)) cnt_d = cnt_q - BWLENGTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        len_q <= '0;
        cnt_q <= '0;
      end else begin
        len_q <= len_d;
        cnt_q <= cnt_d;
      end
    end

    assign z[gi] = (cnt_q == '0);
  end

  always_comb begin
    cur_addr_d = cur_addr_q;
    oc_d       = oc_q;
    jmp_d      = jmp_q;
    if (start_ok) begin
      cur_addr_d = baseaddr;
      oc_d       = count;
      jmp_d      = j_in;
    end else if (accept) begin
      cur_addr_d = cur_addr_q + jmp_q[sel];
      if (sel == 3'd0) oc_d = oc_q - BWLENGTH'(1);
    end
  end

  // The write request register holds through a stall; a fresh accept replaces it in the grant cycle.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cur_addr_q;
      mem_wdata_d = in_data;
    end else if (mem_gnt) begin
      mem_we_d    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (count != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (last_word) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_we_q & mem_gnt) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      oc_q        <= '0;
      jmp_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      oc_q        <= oc_d;
      jmp_q       <= jmp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_wbagu.sv
// Bench for wbagu: table of jobs driven through a nested-loop address model and
// a write scoreboard, plus hand sequences for mid-job reset and idle start.
module tb_wbagu;
  localparam int AW = 21;
  localparam int LW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          clr, start, in_valid, in_ready, mem_we, mem_gnt, busy, done;
  logic [AW-1:0] baseaddr, j0, j1, j2, j3, j4, mem_addr;
  logic [LW-1:0] count, l1, l2, l3, l4;
  logic [DW-1:0] in_data, mem_wdata;

  always #5 clk = ~clk;

  wbagu #(.BWADDR(AW), .BWLENGTH(LW), .BWDATA(DW), .NJUMPS(5)) dut (
    .clk(clk), .clr(clr), .start(start), .baseaddr(baseaddr), .count(count),
    .l1(l1), .l2(l2), .l3(l3), .l4(l4),
    .j0(j0), .j1(j1), .j2(j2), .j3(j3), .j4(j4),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] cnt;
    logic [LW-1:0] l1, l2, l3, l4;
    logic [AW-1:0] j0, j1, j2, j3, j4;
    int            gmode;
    int            vmode;
    bit            mid_start;
    int            exp_words;
    logic [AW-1:0] exp_last;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          sb[$];
  logic [AW-1:0] m_addr;
  int            a1, a2, a3, a4;
  vec_t          vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] base, input logic [LW-1:0] cnt,
                              input logic [LW-1:0] ll1, ll2, ll3, ll4,
                              input logic [AW-1:0] jj0, jj1, jj2, jj3, jj4,
                              input int gmode, vmode, input bit mid,
                              input int words, input logic [AW-1:0] last);
    vec_t v;
    v.base = base; v.cnt = cnt;
    v.l1 = ll1; v.l2 = ll2; v.l3 = ll3; v.l4 = ll4;
    v.j0 = jj0; v.j1 = jj1; v.j2 = jj2; v.j3 = jj3; v.j4 = jj4;
    v.gmode = gmode; v.vmode = vmode; v.mid_start = mid;
    v.exp_words = words; v.exp_last = last;
    return v;
  endfunction

  // Nested-loop reference: the innermost index that can still advance picks the jump.
  function automatic void model_step(input vec_t v);
    if (a4 < int'(v.l4)) begin
      a4++; m_addr = m_addr + v.j4;
    end else begin
      a4 = 0;
      if (a3 < int'(v.l3)) begin
        a3++; m_addr = m_addr + v.j3;
      end else begin
        a3 = 0;
        if (a2 < int'(v.l2)) begin
          a2++; m_addr = m_addr + v.j2;
        end else begin
          a2 = 0;
          if (a1 < int'(v.l1)) begin
            a1++; m_addr = m_addr + v.j1;
          end else begin
            a1 = 0; m_addr = m_addr + v.j0;
          end
        end
      end
    end
  endfunction

  task automatic load_cfg(input vec_t v);
    baseaddr = v.base; count = v.cnt;
    l1 = v.l1; l2 = v.l2; l3 = v.l3; l4 = v.l4;
    j0 = v.j0; j1 = v.j1; j2 = v.j2; j3 = v.j3; j4 = v.j4;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int            acc = 0, wr = 0, we_cycles = 0, done_cyc = -1, last_gnt_cyc = -1;
    bit            stall_prev = 0, have = 0, finished = 0;
    logic [AW-1:0] p_addr = '0, last_addr = '0;
    logic [DW-1:0] p_data = '0, cur = '0;
    exp_t          e;
    @(negedge clk);
    load_cfg(v);
    start = 1'b1; in_valid = 1'b0; mem_gnt = 1'b0;
    sb.delete();
    m_addr = v.base; a1 = 0; a2 = 0; a3 = 0; a4 = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = v.mid_start && (cyc == 4);
      if (start) begin baseaddr = 21'h55; count = 8'd9; end
      case (v.gmode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = ((cyc % 4) == 3);
        default: mem_gnt = 1'($urandom_range(0, 1));
      endcase
      if (!have) begin cur = {$urandom, $urandom}; have = 1; end
      in_valid = (acc < v.exp_words) && (v.vmode == 0 || $urandom_range(0, 2) != 0);
      in_data  = cur;
      #1;
      if (stall_prev) begin
        check({tag, " hold_addr"}, 64'(mem_addr), 64'(p_addr));
        check({tag, " hold_data"}, mem_wdata, p_data);
      end
      stall_prev = mem_we && !mem_gnt;
      if (stall_prev) begin
        check({tag, " stall_in_ready"}, 64'(in_ready), 64'(0));
        p_addr = mem_addr; p_data = mem_wdata;
      end
      if (mem_we) we_cycles++;
      if (mem_we && mem_gnt) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL %s extra_write: got addr 0x%0h, expected no write", tag, mem_addr);
        end else begin
          e = sb.pop_front();
          check({tag, " wr_addr"}, 64'(mem_addr), 64'(e.addr));
          check({tag, " wr_data"}, mem_wdata, e.data);
        end
        wr++; last_addr = mem_addr; last_gnt_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{m_addr, in_data});
        model_step(v);
        acc++; have = 0;
      end
      if (done) begin done_cyc = cyc; finished = 1; end
    end
    if (!finished) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: got no done pulse, expected one within 3000 cycles", tag);
    end
    check({tag, " words_written"}, 64'(wr), 64'(v.exp_words));
    check({tag, " words_accepted"}, 64'(acc), 64'(v.exp_words));
    check({tag, " sb_empty"}, 64'(sb.size()), 64'(0));
    if (v.exp_words > 0) begin
      check({tag, " last_addr"}, 64'(last_addr), 64'(v.exp_last));
      check({tag, " done_latency"}, 64'(done_cyc), 64'(last_gnt_cyc + 1));
    end else begin
      check({tag, " done_next_cycle"}, 64'(done_cyc), 64'(0));
      check({tag, " no_mem_we"}, 64'(we_cycles), 64'(0));
    end
    @(negedge clk);
    in_valid = 1'b0; mem_gnt = 1'b0; start = 1'b0;
    #1;
    check({tag, " busy_after"}, 64'(busy), 64'(0));
    check({tag, " done_single"}, 64'(done), 64'(0));
    check({tag, " we_after"}, 64'(mem_we), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_we"},    64'(mem_we),    64'(0));
    check({tag, " mem_addr"},  64'(mem_addr),  64'(0));
    check({tag, " mem_wdata"}, mem_wdata,      64'(0));
    check({tag, " busy"},      64'(busy),      64'(0));
    check({tag, " done"},      64'(done),      64'(0));
    check({tag, " in_ready"},  64'(in_ready),  64'(0));
  endtask

  initial begin
    int acc;
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_gnt = 1'b0;
    baseaddr = '0; count = '0; l1 = '0; l2 = '0; l3 = '0; l4 = '0;
    j0 = '0; j1 = '0; j2 = '0; j3 = '0; j4 = '0;

    vecs[0] = mk(21'h100, 8'd3, 0, 0, 0, 0, 21'd1, 0, 0, 0, 0, 0, 0, 0, 3, 21'h102);
    vecs[1] = mk(21'h0, 8'd2, 0, 0, 0, 2, 21'd16, 0, 0, 0, 21'd4, 0, 0, 0, 6, 21'd32);
    vecs[2] = mk(21'h1FFFFF, 8'd2, 0, 0, 0, 0, 21'd1, 0, 0, 0, 0, 0, 0, 0, 2, 21'h0);
    vecs[3] = mk(21'h0, 8'd2, 0, 0, 0, 2, 21'd16, 0, 0, 0, 21'd4, 1, 0, 0, 6, 21'd32);
    vecs[4] = mk(21'h1000, 8'd2, 1, 1, 1, 1, 21'h800, 21'h1FFF00, 21'h40, 21'h1FFFFF, 21'd2,
                 2, 1, 1, 32, 21'h1718);
    vecs[5] = mk(21'h300, 8'd0, 1, 1, 0, 0, 21'd1, 0, 0, 0, 0, 0, 0, 0, 0, 21'h0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    clr = 1'b0;

    for (int k = 0; k < 6; k++) begin
      string tag;
      tag = $sformatf("job%0d", k);
      run_job(vecs[k], tag);
    end

    // Abandon a job after two accepted words, then rerun it from scratch.
    @(negedge clk);
    load_cfg(vecs[1]);
    start = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 2; cyc++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom}; mem_gnt = 1'b1;
      #1;
      if (in_valid && in_ready) acc++;
    end
    check("abort accepted_two", 64'(acc), 64'(2));
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b1; start = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("abort");
    clr = 1'b0; start = 1'b0; mem_gnt = 1'b0;
    run_job(vecs[1], "restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
